// File: rtl/pc_pkg.sv
// Shared types and default constants for the pc_gen program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0040_0004;
  localparam int          PC_INC       = 4;

  // A fetch target must be word aligned; any set low bit is a misalignment.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch/redirect bundle between pc_gen (master) and the fetch/branch side (slave).
// misalign_exc exists only when PC_ALIGN_CHK_EN is defined.
interface pc_gen_if #(parameter int WIDTH = 32) ();
  logic             ena;
  logic             pc_ready;
  logic             redir_valid;
  logic [WIDTH-1:0] redir_target;
  logic             halt_req;
  logic [WIDTH-1:0] data_out;
  logic             pc_valid;
  logic             redir_pending;
  logic             halted;
`ifdef PC_ALIGN_CHK_EN
  logic             misalign_exc;

  modport master (
    input  ena, pc_ready, redir_valid, redir_target, halt_req,
    output data_out, pc_valid, redir_pending, halted, misalign_exc
  );
  modport slave (
    output ena, pc_ready, redir_valid, redir_target, halt_req,
    input  data_out, pc_valid, redir_pending, halted, misalign_exc
  );
`else
  modport master (
    input  ena, pc_ready, redir_valid, redir_target, halt_req,
    output data_out, pc_valid, redir_pending, halted
  );
  modport slave (
    output ena, pc_ready, redir_valid, redir_target, halt_req,
    input  data_out, pc_valid, redir_pending, halted
  );
`endif
endinterface

// File: rtl/pc_redir_hold.sv
// Holds one deferred redirect target; a new capture overwrites (last wins),
// clear drops it once the target has been applied.
module pc_redir_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_target
);

  // Pending flag and target register; capture takes precedence over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (capture) begin
      pend_valid  <= 1'b1;
      pend_target <= target;
    end else if (clear) begin
      pend_valid  <= 1'b0;
      pend_target <= pend_target;
    end else begin
      pend_valid  <= pend_valid;
      pend_target <= pend_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with valid/ready fetch handshake, deferred redirects
// and HALT. Optional alignment trap enabled by defining PC_ALIGN_CHK_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
`ifdef PC_ALIGN_CHK_EN
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
`endif
  parameter int               INC       = PC_INC
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);

  pc_state_e        state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic             valid, valid_nxt;
  logic             halt_flag, halt_nxt;
  logic             exc_flag, exc_nxt;
  logic             capture, clear;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             have_target;
  logic [WIDTH-1:0] sel_target;
  logic [WIDTH-1:0] applied_target;
  logic             target_bad;

  pc_redir_hold #(.WIDTH(WIDTH)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .clear       (clear),
    .target      (bus.redir_target),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

  // Live redirect beats a held one; the held one is discarded when both exist.
  always_comb begin
    have_target = bus.redir_valid | pend_valid;
    sel_target  = bus.redir_valid ? bus.redir_target : pend_target;
`ifdef PC_ALIGN_CHK_EN
    target_bad     = is_misaligned(sel_target[1:0]);
    applied_target = target_bad ? EXC_VEC : sel_target;
`else
    target_bad     = 1'b0;
    applied_target = sel_target;
`endif
  end

  // Next-state, next-PC and redirect hold control.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    clear     = 1'b0;
    exc_nxt   = 1'b0;
    if (!bus.ena) begin
      // Frozen: only redirect capture stays live.
      capture = bus.redir_valid;
    end else begin
      case (state)
        ST_BOOT: begin
          state_nxt = ST_RUN;
          capture   = bus.redir_valid;
        end
        ST_RUN: begin
          if (have_target) begin
            pc_nxt  = applied_target;
            clear   = 1'b1;
            exc_nxt = target_bad;
          end else if (bus.pc_ready) begin
            pc_nxt = pc + WIDTH'(INC);
          end else begin
            pc_nxt = pc;
          end
          if (bus.halt_req) begin
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_HALT: begin
          if (have_target) begin
            pc_nxt    = applied_target;
            clear     = 1'b1;
            exc_nxt   = target_bad;
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_HALT;
          end
        end
        default: begin
          state_nxt = ST_BOOT;
        end
      endcase
    end
    valid_nxt = (state_nxt == ST_RUN);
    halt_nxt  = (state_nxt == ST_HALT);
  end

  // State, PC and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      pc        <= RESET_VEC;
      valid     <= 1'b0;
      halt_flag <= 1'b0;
      exc_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      valid     <= valid_nxt;
      halt_flag <= halt_nxt;
      exc_flag  <= exc_nxt;
    end
  end

  assign bus.data_out      = pc;
  assign bus.pc_valid      = valid;
  assign bus.halted        = halt_flag;
  assign bus.redir_pending = pend_valid;
`ifdef PC_ALIGN_CHK_EN
  assign bus.misalign_exc  = exc_flag;
`else
  logic unused_exc;
  assign unused_exc = exc_flag;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed test-plan sequences with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0040_0000;
`ifdef PC_ALIGN_CHK_EN
  localparam logic [31:0] EV = 32'h0040_0004;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.WIDTH(32)) bus ();
  pc_gen_if #(.WIDTH(16)) bus16 ();

  pc_gen #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_gen #(.WIDTH(16), .RESET_VEC(16'hFFFC), .INC(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase flags, PC value and a one-entry redirect mailbox.
  logic [31:0] m_pc, m_ptgt, m_t;
  bit          m_booting, m_halted, m_pend, m_exc, m_have;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RV; m_booting = 1; m_halted = 0; m_pend = 0; m_ptgt = 0; m_exc = 0;
    end else begin
      m_exc = 0;
      if (!bus.ena) begin
        if (bus.redir_valid) begin m_pend = 1; m_ptgt = bus.redir_target; end
      end else if (m_booting) begin
        m_booting = 0;
        if (bus.redir_valid) begin m_pend = 1; m_ptgt = bus.redir_target; end
      end else begin
        m_have = bus.redir_valid || m_pend;
        m_t    = bus.redir_valid ? bus.redir_target : m_ptgt;
        if (m_have) begin
          m_pend = 0;
          m_pc   = m_t;
`ifdef PC_ALIGN_CHK_EN
          if (m_t % 4 != 0) begin m_pc = EV; m_exc = 1; end
`endif
          m_halted = m_halted ? 1'b0 : bus.halt_req;
        end else if (!m_halted) begin
          if (bus.pc_ready) m_pc = m_pc + 32'd4;
          m_halted = bus.halt_req;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    chk("model_pc", bus.data_out, m_pc);
    chk("model_valid", {31'd0, bus.pc_valid}, {31'd0, !m_booting && !m_halted});
    chk("model_halted", {31'd0, bus.halted}, {31'd0, m_halted});
    chk("model_pending", {31'd0, bus.redir_pending}, {31'd0, m_pend});
`ifdef PC_ALIGN_CHK_EN
    chk("model_misalign", {31'd0, bus.misalign_exc}, {31'd0, m_exc});
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.redir_valid  = 1'b0;
    bus.redir_target = 32'd0;
    bus.halt_req     = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.ena = 1'b0; bus.pc_ready = 1'b0; idle_inputs();
    bus16.ena = 1'b1; bus16.pc_ready = 1'b1; bus16.redir_valid = 1'b0;
    bus16.redir_target = 16'd0; bus16.halt_req = 1'b0;
    #1 rst = 1'b1;
    repeat (2) cyc();
    chk("rst_pc", bus.data_out, 32'h0040_0000);
    chk("rst_valid", {31'd0, bus.pc_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_pending", {31'd0, bus.redir_pending}, 32'd0);
    chk("rst_pc16", {16'd0, bus16.data_out}, 32'h0000_FFFC);

    // Sequential fetch from the reset vector.
    rst = 1'b0; bus.ena = 1'b1; bus.pc_ready = 1'b1;
    cyc();
    chk("boot_pc", bus.data_out, 32'h0040_0000);
    chk("boot_valid", {31'd0, bus.pc_valid}, 32'd1);
    chk("w16_first", {16'd0, bus16.data_out}, 32'h0000_FFFC);
    cyc();
    chk("seq_pc1", bus.data_out, 32'h0040_0004);
    chk("w16_wrap", {16'd0, bus16.data_out}, 32'h0000_0000);
    cyc(); chk("seq_pc2", bus.data_out, 32'h0040_0008);
    cyc(); chk("seq_pc3", bus.data_out, 32'h0040_000C);

    // Backpressure holds the offered PC.
    bus.pc_ready = 1'b0;
    repeat (3) cyc();
    chk("stall_pc", bus.data_out, 32'h0040_000C);
    chk("stall_valid", {31'd0, bus.pc_valid}, 32'd1);
    bus.pc_ready = 1'b1;
    cyc(); chk("unstall_pc", bus.data_out, 32'h0040_0010);

    // Frozen redirects: last one wins and lands on the first enabled edge.
    bus.ena = 1'b0; bus.pc_ready = 1'b0;
    bus.redir_valid = 1'b1; bus.redir_target = 32'h0040_0100; cyc();
    bus.redir_target = 32'h0040_0200; cyc();
    idle_inputs(); cyc();
    chk("frz_pending", {31'd0, bus.redir_pending}, 32'd1);
    chk("frz_pc", bus.data_out, 32'h0040_0010);
    bus.ena = 1'b1;
    cyc();
    chk("pend_apply_pc", bus.data_out, 32'h0040_0200);
    chk("pend_cleared", {31'd0, bus.redir_pending}, 32'd0);

    // Halt after a completed transfer, then release by redirect.
    bus.redir_valid = 1'b1; bus.redir_target = 32'h0040_0010; cyc();
    idle_inputs(); bus.halt_req = 1'b1; bus.pc_ready = 1'b1; cyc();
    chk("halt_pc", bus.data_out, 32'h0040_0014);
    chk("halt_flag", {31'd0, bus.halted}, 32'd1);
    chk("halt_valid", {31'd0, bus.pc_valid}, 32'd0);
    cyc();
    chk("halt_hold", bus.data_out, 32'h0040_0014);
    bus.halt_req = 1'b0; bus.redir_valid = 1'b1; bus.redir_target = 32'h0040_0040; cyc();
    chk("release_pc", bus.data_out, 32'h0040_0040);
    chk("release_valid", {31'd0, bus.pc_valid}, 32'd1);
    chk("release_halted", {31'd0, bus.halted}, 32'd0);
    idle_inputs();

`ifdef PC_ALIGN_CHK_EN
    bus.redir_valid = 1'b1; bus.redir_target = 32'h0040_0102; cyc();
    chk("mis_pc", bus.data_out, 32'h0040_0004);
    chk("mis_flag", {31'd0, bus.misalign_exc}, 32'd1);
    idle_inputs(); bus.pc_ready = 1'b0; cyc();
    chk("mis_pulse", {31'd0, bus.misalign_exc}, 32'd0);
`endif

    // Randomized traffic, including occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      bus.ena          = ($urandom_range(0, 7) != 0);
      bus.pc_ready     = $urandom_range(0, 1) == 1;
      bus.redir_valid  = ($urandom_range(0, 9) == 0);
      bus.redir_target = $urandom;
      if ($urandom_range(0, 1) == 1) bus.redir_target[1:0] = 2'b00;
      bus.halt_req     = ($urandom_range(0, 15) == 0);
      rst              = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; idle_inputs();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator; successor to the single 32-bit enable-gated PC register. Drives the fetch stage over a valid/ready handshake and applies redirects from branch/jump/exception logic. A redirect raised while the PC is frozen is held and applied on the next enabled cycle. Supports a halt state and a configurable reset vector and increment.

Parameters:
WIDTH, 32, PC width in bits
RESET_VEC, 32'h0040_0000, PC value loaded by reset (WIDTH bits)
INC, 4, sequential increment added per accepted fetch
EXC_VEC, 32'h0040_0004, trap target; used only when PC_ALIGN_CHK_EN is defined

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
ena  in  1  global enable; 0 freezes all state except redirect capture
pc_ready  in  1  fetch stage accepts data_out this cycle
redir_valid  in  1  redirect request, single-cycle pulse
redir_target  in  WIDTH  redirect destination
halt_req  in  1  stop issuing PCs after the current one
data_out  out  WIDTH  current PC
pc_valid  out  1  data_out is a valid fetch address
redir_pending  out  1  a captured redirect is waiting to be applied
halted  out  1  block is in HALT state

Behaviour:
- Reset (async, rst=1): data_out=RESET_VEC, pc_valid=0, redir_pending=0, halted=0, state=BOOT, pending target=0.
- States: BOOT, RUN, HALT. pc_valid=1 only in RUN. halted=1 only in HALT.
- BOOT -> RUN on the first clock edge with ena=1. data_out stays at RESET_VEC, so the first fetched PC is RESET_VEC.
- RUN, ena=1, priority order:
  1. redir_valid: data_out<=redir_target; pending cleared.
  2. Else redir_pending: data_out<=pending target; pending cleared.
  3. Else pc_ready=1: data_out<=data_out+INC, wrapping modulo 2^WIDTH.
  4. Else hold.
- Redirects (steps 1-2) apply regardless of pc_ready; they flush the offered PC. This is the only case where data_out changes while pc_valid=1 and pc_ready=0.
- halt_req in RUN with ena=1: the current transfer completes if pc_ready=1, then state<=HALT.
  - If redir_valid arrives in the same cycle, the redirect is applied and HALT is still entered.
- HALT: data_out held, pc_valid=0.
  - redir_valid with ena=1 -> data_out<=redir_target, state<=RUN.
  - halt_req is ignored while in HALT.
- ena=0 in any state: data_out, state and halted are frozen.
  - redir_valid is still captured: pending<=redir_target, redir_pending<=1.
  - A later redirect overwrites the earlier pending one (last wins).
  - A pending redirect is applied on the first ena=1 cycle in RUN, or releases HALT.
- A live redir_valid in the same cycle as a pending redirect wins; the pending one is discarded.
- Latency: a redirect with ena=1 appears on data_out the next cycle.
- rst asserted mid-operation discards pending and HALT immediately.

Optional Feature:
PC_ALIGN_CHK_EN
- Defined:
  - Any applied target (live or pending) with target[1:0]!=0 loads EXC_VEC instead.
  - Adds output misalign_exc (1 bit), high for exactly one cycle when the substitution takes effect.
  - misalign_exc resets to 0.
- Undefined: targets are loaded unchanged and the port is absent.

Decomposition:
- Package pc_pkg:
  - state enum (BOOT/RUN/HALT, 2-bit encoding)
  - default RESET_VEC, EXC_VEC and INC constants
- One sub-module, pc_redir_hold: pending-target register plus valid flag with capture/clear/override logic.
- The FSM and adder stay in pc_gen.

Test Plan:
- rst pulse, then ena=1, pc_ready=1 for 4 cycles -> data_out 00400000, 00400004, 00400008, 0040000C; pc_valid=0 during BOOT, 1 after.
- pc_ready=0 for 3 cycles in RUN -> data_out and pc_valid stable; on pc_ready=1, advances by 4.
- ena=0, redir_valid with target 00400100, then target 00400200; ena=1 two cycles later -> redir_pending=1 while frozen; data_out=00400200 on the first enabled edge; pending cleared.
- halt_req with pc_ready=1 at 00400010 -> data_out 00400014, halted=1, pc_valid=0; redir_valid 00400040 -> RUN at 00400040.
- WIDTH=16, RESET_VEC=16'hFFFC, INC=4 -> data_out FFFC then 0000 (wrap).
- PC_ALIGN_CHK_EN defined, redirect to 00400102 -> data_out=EXC_VEC, misalign_exc=1 for one cycle.
